// File: rtl/msff_stretch_bank.sv
// msff_stretch_bank: bank of master/slave flops, each bit
// with a retriggerable programmable output pulse stretcher.
module msff_stretch_bank #(
  parameter int WIDTH = 6,
  parameter int CNTW  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  input  logic [CNTW-1:0]  stretchLen,
  input  logic [WIDTH-1:0] stretchEn,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] stretching,
  output logic             anyStretching
);

  logic [WIDTH-1:0]           master_q;
  logic [WIDTH-1:0]           master_d;
  logic [WIDTH-1:0]           out_q;
  logic [WIDTH-1:0]           out_d;
  logic [WIDTH-1:0][CNTW-1:0] cnt_q;
  logic [WIDTH-1:0][CNTW-1:0] cnt_d;
  logic [WIDTH-1:0]           busy;

  // master follows d, slave follows master
  always_comb begin
    master_d = d;
    out_d    = master_q;
  end

  // stretch counters: reload while master high, else count down
  always_comb begin
    cnt_d = cnt_q;
    busy  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      busy[i] = (cnt_q[i] != '0);
      if (master_q[i]) begin
        cnt_d[i] = stretchEn[i] ? stretchLen : '0;
      end else if (busy[i]) begin
        cnt_d[i] = cnt_q[i] - CNTW'(1);
      end else begin
        cnt_d[i] = '0;
      end
    end
  end

  // falling-edge state: master latch and stretch counters
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      master_q <= '0;
      cnt_q    <= '0;
    end else begin
      master_q <= master_d;
      cnt_q    <= cnt_d;
    end
  end

  // rising-edge state: slave output
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  // outputs: slave ORed with stretch, and stretch-only indication
  always_comb begin
    q             = out_q | busy;
    stretching    = busy & ~out_q;
    anyStretching = |stretching;
  end

endmodule

// File: tb/tb_msff_stretch_bank.sv
// tb_msff_stretch_bank: directed scenarios with expected
// half-cycle waveforms queued and checked by a monitor.
module tb_msff_stretch_bank;

  localparam int W = 6;
  localparam int C = 3;

  logic         clk;
  logic         reset;
  logic [W-1:0] d;
  logic [C-1:0] stretchLen;
  logic [W-1:0] stretchEn;
  logic [W-1:0] q;
  logic [W-1:0] stretching;
  logic         anyStretching;

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0] exp_q [$];
  logic [W-1:0] exp_s [$];

  logic [W-1:0] dv   [64];
  logic [W-1:0] ev   [64];
  logic [C-1:0] lv   [64];
  logic [W-1:0] eq_q [128];
  logic [W-1:0] eq_s [128];
  int           ncyc;

  msff_stretch_bank #(
    .WIDTH(W),
    .CNTW (C)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .d            (d),
    .stretchLen   (stretchLen),
    .stretchEn    (stretchEn),
    .q            (q),
    .stretching   (stretching),
    .anyStretching(anyStretching)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t",
               nm, act, exp, $time);
    end
  endtask

  // monitor: one expected entry per half clock, sampled mid-phase
  initial begin
    logic [W-1:0] eq;
    logic [W-1:0] es;
    forever begin
      @(clk);
      #5;
      if (exp_q.size() > 0) begin
        eq = exp_q.pop_front();
        es = exp_s.pop_front();
        chk("q", q, eq);
        chk("stretching", stretching, es);
        chk("anyStretching", W'(anyStretching), W'(|es));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic clr(input int n);
    ncyc = n;
    for (int c = 0; c < 64; c++) begin
      dv[c] = '0;
      ev[c] = '1;
      lv[c] = '0;
    end
    for (int h = 0; h < 128; h++) begin
      eq_q[h] = '0;
      eq_s[h] = '0;
    end
  endtask

  task automatic pulse(input int b, input int a, input int e);
    for (int c = a; c < e; c++) dv[c][b] = 1'b1;
  endtask

  task automatic setlen(input int from, input logic [C-1:0] l);
    for (int c = from; c < 64; c++) lv[c] = l;
  endtask

  task automatic win(input int b, input int r, input int f,
                     input int ss, input int se);
    for (int h = r; h < f; h++) eq_q[h][b] = 1'b1;
    for (int h = ss; h < se; h++) eq_s[h][b] = 1'b1;
  endtask

  // drive one scenario; entered and left just after a posedge
  task automatic run_scn();
    for (int c = 0; c < ncyc; c++) begin
      d          = dv[c];
      stretchEn  = ev[c];
      stretchLen = lv[c];
      @(negedge clk);
      #1;
      exp_q.push_back(eq_q[2*c]);
      exp_s.push_back(eq_s[2*c]);
      @(posedge clk);
      #1;
      exp_q.push_back(eq_q[2*c+1]);
      exp_s.push_back(eq_s[2*c+1]);
    end
    #6;
  endtask

  task automatic do_reset();
    d     = '0;
    reset = 1'b1;
    #2;
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  int sl [4] = '{0, 1, 3, 7};
  int sf [4] = '{5, 6, 10, 18};

  initial begin
    reset      = 1'b1;
    d          = '1;
    stretchEn  = '1;
    stretchLen = 3'd7;
    #15;
    chk("rst_q", q, '0);
    chk("rst_str", stretching, '0);
    chk("rst_any", W'(anyStretching), '0);
    repeat (2) @(posedge clk);
    #3;
    chk("rst_hold_q", q, '0);
    chk("rst_hold_any", W'(anyStretching), '0);
    d     = '0;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // length sweep on bit 2
    for (int k = 0; k < 4; k++) begin
      clr(5 + sl[k]);
      setlen(0, C'(sl[k]));
      pulse(2, 1, 2);
      win(2, 3, sf[k], 5, sf[k]);
      run_scn();
      do_reset();
    end

    // retrigger with mid-tail length change
    clr(12);
    setlen(0, 3'd4);
    setlen(5, 3'd2);
    pulse(1, 1, 4);
    pulse(1, 6, 7);
    win(1, 3, 18, 9, 13);
    win(1, 0, 0, 15, 18);
    run_scn();
    do_reset();

    // per-bit enable
    clr(10);
    setlen(0, 3'd5);
    for (int c = 0; c < 64; c++) ev[c] = 6'b101010;
    for (int i = 0; i < W; i++) begin
      pulse(i, 1, 2);
      if (i % 2 == 1) win(i, 3, 14, 5, 14);
      else win(i, 3, 5, 0, 0);
    end
    run_scn();
    do_reset();

    // enable dropped mid-tail: tail survives, next load is 0
    clr(10);
    setlen(0, 3'd3);
    for (int c = 3; c < 64; c++) ev[c][0] = 1'b0;
    pulse(0, 1, 2);
    pulse(0, 6, 7);
    win(0, 3, 10, 5, 10);
    win(0, 13, 15, 0, 0);
    run_scn();
    do_reset();

    // staggered channels
    clr(16);
    setlen(0, 3'd3);
    for (int i = 0; i < W; i++) begin
      pulse(i, 1 + i, 2 + i);
      win(i, 3 + 2*i, 10 + 2*i, 5 + 2*i, 10 + 2*i);
    end
    run_scn();
    do_reset();

    // reset mid-tail with counter at 3
    clr(7);
    setlen(0, 3'd7);
    pulse(0, 1, 2);
    win(0, 3, 18, 5, 18);
    run_scn();
    reset = 1'b1;
    #1;
    chk("midrst_q", q, '0);
    chk("midrst_str", stretching, '0);
    chk("midrst_any", W'(anyStretching), '0);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // first edges after release sample d normally
    clr(5);
    for (int c = 0; c < 64; c++) ev[c] = '0;
    pulse(0, 0, 3);
    win(0, 1, 7, 0, 0);
    run_scn();

    chk("queue_drained", W'(exp_q.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
